// File: rtl/oled_init_ctrl.sv
// Power-up sequencer for an SSD1306-class OLED: panel reset, init command table,
// full-screen clear, then single-byte user writes through a req/ack handshake.
module oled_init_ctrl #(
    parameter logic [15:0] RES_CYCLES  = 16'd250,
    parameter logic [15:0] WAIT_CYCLES = 16'd2500,
    parameter logic [10:0] CLEAR_BYTES = 11'd1024
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [9:0] SPI_DATA,
    output logic       SPI_START,
    input  logic       SPI_DONE,
    output logic       OLED_RES,
    input  logic       WR_REQ,
    input  logic       WR_DC,
    input  logic [7:0] WR_BYTE,
    output logic       WR_ACK,
    output logic       READY
);

    typedef enum logic [2:0] {
        S_RES,
        S_WAIT,
        S_INIT,
        S_WIN,
        S_CLR,
        S_READY
    } state_t;

    localparam logic [9:0]  IDLE_DATA = 10'h3FF;
    // A zero-length phase still occupies one cycle, so the terminal count clamps at 0.
    localparam logic [15:0] RES_LAST  = (RES_CYCLES  == 16'd0) ? 16'd0 : RES_CYCLES  - 16'd1;
    localparam logic [15:0] WAIT_LAST = (WAIT_CYCLES == 16'd0) ? 16'd0 : WAIT_CYCLES - 16'd1;
    localparam logic [10:0] INIT_LAST = 11'd24;
    localparam logic [10:0] WIN_LAST  = 11'd5;
    localparam logic [10:0] CLR_LAST  = (CLEAR_BYTES == 11'd0) ? 11'd0 : CLEAR_BYTES - 11'd1;

    function automatic logic [7:0] init_byte(input logic [4:0] i);
        case (i)
            5'd0:  init_byte = 8'hAE;
            5'd1:  init_byte = 8'hD5;
            5'd2:  init_byte = 8'h80;
            5'd3:  init_byte = 8'hA8;
            5'd4:  init_byte = 8'h3F;
            5'd5:  init_byte = 8'hD3;
            5'd6:  init_byte = 8'h00;
            5'd7:  init_byte = 8'h40;
            5'd8:  init_byte = 8'h8D;
            5'd9:  init_byte = 8'h14;
            5'd10: init_byte = 8'h20;
            5'd11: init_byte = 8'h00;
            5'd12: init_byte = 8'hA1;
            5'd13: init_byte = 8'hC8;
            5'd14: init_byte = 8'hDA;
            5'd15: init_byte = 8'h12;
            5'd16: init_byte = 8'h81;
            5'd17: init_byte = 8'hCF;
            5'd18: init_byte = 8'hD9;
            5'd19: init_byte = 8'hF1;
            5'd20: init_byte = 8'hDB;
            5'd21: init_byte = 8'h40;
            5'd22: init_byte = 8'hA4;
            5'd23: init_byte = 8'hA6;
            5'd24: init_byte = 8'hAF;
            default: init_byte = 8'hE3;
        endcase
    endfunction

    function automatic logic [7:0] win_byte(input logic [2:0] i);
        case (i)
            3'd0: win_byte = 8'h21;
            3'd1: win_byte = 8'h00;
            3'd2: win_byte = 8'h7F;
            3'd3: win_byte = 8'h22;
            3'd4: win_byte = 8'h00;
            3'd5: win_byte = 8'h07;
            default: win_byte = 8'hE3;
        endcase
    endfunction

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [10:0] idx_reg, idx_next;
    logic        busy_reg, busy_next;
    logic [9:0]  spi_data_reg, spi_data_next;
    logic        spi_start_reg, spi_start_next;
    logic        oled_res_reg, oled_res_next;
    logic        wr_ack_reg, wr_ack_next;
    logic        ready_reg, ready_next;
    logic        done_ok;

    // DONE only counts once the start pulse is over and a byte is in flight.
    assign done_ok = busy_reg && !spi_start_reg && SPI_DONE;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        busy_next      = busy_reg;
        spi_data_next  = spi_data_reg;
        spi_start_next = 1'b0;
        oled_res_next  = oled_res_reg;
        wr_ack_next    = 1'b0;
        ready_next     = ready_reg;

        case (state_reg)
            S_RES: begin
                oled_res_next = 1'b0;
                if (cnt_reg >= RES_LAST) begin
                    state_next    = S_WAIT;
                    cnt_next      = 16'd0;
                    oled_res_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_WAIT: begin
                if (cnt_reg >= WAIT_LAST) begin
                    // The first command goes out on the same edge the wait ends.
                    state_next     = S_INIT;
                    cnt_next       = 16'd0;
                    idx_next       = 11'd0;
                    spi_data_next  = {2'b00, init_byte(5'd0)};
                    spi_start_next = 1'b1;
                    busy_next      = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            S_INIT: begin
                if (!busy_reg) begin
                    spi_data_next  = {2'b00, init_byte(idx_reg[4:0])};
                    spi_start_next = 1'b1;
                    busy_next      = 1'b1;
                end else if (done_ok) begin
                    spi_data_next = IDLE_DATA;
                    busy_next     = 1'b0;
                    if (idx_reg >= INIT_LAST) begin
                        state_next = S_WIN;
                        idx_next   = 11'd0;
                    end else begin
                        idx_next = idx_reg + 11'd1;
                    end
                end
            end
            S_WIN: begin
                if (!busy_reg) begin
                    spi_data_next  = {2'b00, win_byte(idx_reg[2:0])};
                    spi_start_next = 1'b1;
                    busy_next      = 1'b1;
                end else if (done_ok) begin
                    spi_data_next = IDLE_DATA;
                    busy_next     = 1'b0;
                    if (idx_reg >= WIN_LAST) begin
                        state_next = S_CLR;
                        idx_next   = 11'd0;
                    end else begin
                        idx_next = idx_reg + 11'd1;
                    end
                end
            end
            S_CLR: begin
                if (CLEAR_BYTES == 11'd0) begin
                    state_next = S_READY;
                    ready_next = 1'b1;
                end else if (!busy_reg) begin
                    spi_data_next  = 10'h100;
                    spi_start_next = 1'b1;
                    busy_next      = 1'b1;
                end else if (done_ok) begin
                    spi_data_next = IDLE_DATA;
                    busy_next     = 1'b0;
                    if (idx_reg >= CLR_LAST) begin
                        state_next = S_READY;
                        idx_next   = 11'd0;
                        ready_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + 11'd1;
                    end
                end
            end
            S_READY: begin
                // A request seen while ACK is high belongs to the byte just finished.
                if (!busy_reg) begin
                    if (WR_REQ && !wr_ack_reg) begin
                        spi_data_next  = {1'b0, WR_DC, WR_BYTE};
                        spi_start_next = 1'b1;
                        busy_next      = 1'b1;
                    end
                end else if (done_ok) begin
                    spi_data_next = IDLE_DATA;
                    busy_next     = 1'b0;
                    wr_ack_next   = 1'b1;
                end
            end
            default: begin
                state_next = S_RES;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= S_RES;
            cnt_reg       <= 16'd0;
            idx_reg       <= 11'd0;
            busy_reg      <= 1'b0;
            spi_data_reg  <= IDLE_DATA;
            spi_start_reg <= 1'b0;
            oled_res_reg  <= 1'b0;
            wr_ack_reg    <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            busy_reg      <= busy_next;
            spi_data_reg  <= spi_data_next;
            spi_start_reg <= spi_start_next;
            oled_res_reg  <= oled_res_next;
            wr_ack_reg    <= wr_ack_next;
            ready_reg     <= ready_next;
        end
    end

    assign SPI_DATA  = spi_data_reg;
    assign SPI_START = spi_start_reg;
    assign OLED_RES  = oled_res_reg;
    assign WR_ACK    = wr_ack_reg;
    assign READY     = ready_reg;

endmodule

// File: tb/tb_oled_init_ctrl.sv
// Bench for oled_init_ctrl: SPI transmitter model with variable latency and a
// table-driven expected byte stream, plus reset, user-write and abort scenarios.
module tb_oled_init_ctrl;

    localparam logic [15:0] RES_C   = 16'd4;
    localparam logic [15:0] WAIT_C  = 16'd8;
    localparam logic [10:0] CLEAR_C = 11'd16;
    localparam int          N_BYTES = 25 + 6 + 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] spi_data;
    logic       spi_start;
    logic       spi_done = 1'b0;
    logic       oled_res;
    logic       wr_req = 1'b0;
    logic       wr_dc = 1'b0;
    logic [7:0] wr_byte = 8'h00;
    logic       wr_ack;
    logic       ready;

    always #5 clk = ~clk;

    oled_init_ctrl #(
        .RES_CYCLES  (RES_C),
        .WAIT_CYCLES (WAIT_C),
        .CLEAR_BYTES (CLEAR_C)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .SPI_DATA  (spi_data),
        .SPI_START (spi_start),
        .SPI_DONE  (spi_done),
        .OLED_RES  (oled_res),
        .WR_REQ    (wr_req),
        .WR_DC     (wr_dc),
        .WR_BYTE   (wr_byte),
        .WR_ACK    (wr_ack),
        .READY     (ready)
    );

    // Transmitter model: DONE arrives tx_latency cycles after START; also
    // records protocol violations seen on the bus.
    int         tx_latency = 20;
    int         tx_cnt = 0;
    logic       tx_busy = 1'b0;
    logic [9:0] tx_data = 10'h3FF;
    int         start_count = 0;
    int         overlap_count = 0;
    int         data_change_count = 0;
    int         early_ack_count = 0;

    always @(negedge clk) begin
        spi_done = 1'b0;
        if (rst) begin
            tx_busy = 1'b0;
        end else begin
            if (wr_ack && !ready) early_ack_count++;
            if (tx_busy) begin
                if (spi_start) overlap_count++;
                if (spi_data !== tx_data) data_change_count++;
                tx_cnt--;
                if (tx_cnt <= 0) begin
                    spi_done = 1'b1;
                    tx_busy  = 1'b0;
                end
            end else if (spi_start) begin
                tx_busy = 1'b1;
                tx_data = spi_data;
                tx_cnt  = tx_latency;
                start_count++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int passed = 0;
    int total = 0;
    int fails = 0;
    logic [9:0] exp_q[$];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [9:0] exp_data);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (spi_start === 1'b1) seen = 1'b1;
        end
        check({tag, "_start"}, 32'(seen), 32'd1);
        if (seen) check({tag, "_data"}, 32'(spi_data), 32'(exp_data));
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (spi_done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    task automatic user_write(input string tag, input logic dc, input logic [7:0] b);
        int extra;
        wr_req  = 1'b1;
        wr_dc   = dc;
        wr_byte = b;
        expect_byte(tag, {1'b0, dc, b});
        wait_done(tag);
        step();
        check({tag, "_ack"}, 32'(wr_ack), 32'd1);
        check({tag, "_idle"}, 32'(spi_data), 32'h3FF);
        step();
        check({tag, "_ack_1cyc"}, 32'(wr_ack), 32'd0);
        wr_req = 1'b0;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (spi_start === 1'b1) extra++;
        end
        check({tag, "_no_2nd_start"}, 32'(extra), 32'd0);
        $display("write dc=%0d byte=%02h", dc, b);
    endtask

    initial begin
        logic [7:0] init_tbl [25];
        logic [7:0] win_tbl [6];
        int low_cnt;
        int wait_cnt;
        int base;
        logic       pend_dc;
        logic [7:0] pend_byte;

        init_tbl = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                     8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                     8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
        win_tbl  = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        foreach (init_tbl[i]) exp_q.push_back({2'b00, init_tbl[i]});
        foreach (win_tbl[i]) exp_q.push_back({2'b00, win_tbl[i]});
        for (int i = 0; i < int'(CLEAR_C); i++) exp_q.push_back(10'h100);

        // Reset values
        step(); step(); step();
        check("rst_spi_data", 32'(spi_data), 32'h3FF);
        check("rst_spi_start", 32'(spi_start), 32'd0);
        check("rst_oled_res", 32'(oled_res), 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        rst = 1'b0;

        // Panel reset width and power-up wait
        low_cnt = 1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (oled_res === 1'b0) low_cnt++;
            else break;
        end
        check("res_low_cycles", 32'(low_cnt), 32'(RES_C));
        wait_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            wait_cnt++;
            check("res_stays_high", 32'(oled_res), 32'd1);
            if (spi_start === 1'b1) break;
        end
        check("first_start_delay", 32'(wait_cnt), 32'(WAIT_C));
        check("first_byte", 32'(spi_data), 32'(exp_q[0]));
        $display("byte 0 = %03h", spi_data);

        // Full init / window / clear stream
        for (int k = 1; k < N_BYTES; k++) begin
            expect_byte($sformatf("seq%0d", k), exp_q[k]);
        end
        wait_done("last");
        check("ready_before_last_done", 32'(ready), 32'd0);
        step();
        check("ready_after_last_done", 32'(ready), 32'd1);
        check("start_count", 32'(start_count), 32'(N_BYTES));

        // User writes: directed, then randomized byte/type/latency
        user_write("user_a5", 1'b1, 8'hA5);
        for (int k = 0; k < 4; k++) begin
            tx_latency = int'($urandom_range(1, 25));
            user_write($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        check("ready_stays", 32'(ready), 32'd1);

        // Abort while init byte 10 is outstanding
        tx_latency = 20;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            expect_byte($sformatf("pre%0d", k), exp_q[k]);
        end
        repeat (5) step();
        rst = 1'b1;
        step();
        check("abort_spi_data", 32'(spi_data), 32'h3FF);
        check("abort_spi_start", 32'(spi_start), 32'd0);
        check("abort_oled_res", 32'(oled_res), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        rst = 1'b0;

        // Request raised during init must wait for READY
        pend_dc    = 1'($urandom_range(0, 1));
        pend_byte  = 8'($urandom);
        wr_dc      = pend_dc;
        wr_byte    = pend_byte;
        wr_req     = 1'b1;
        tx_latency = 2;
        base = start_count;
        for (int k = 0; k < N_BYTES; k++) begin
            expect_byte($sformatf("re%0d", k), exp_q[k]);
        end
        wait_done("re_last");
        step();
        check("re_ready", 32'(ready), 32'd1);
        check("re_start_count", 32'(start_count - base), 32'(N_BYTES));
        expect_byte("pending", {1'b0, pend_dc, pend_byte});
        wait_done("pending");
        step();
        check("pending_ack", 32'(wr_ack), 32'd1);
        wr_req = 1'b0;
        $display("write dc=%0d byte=%02h (pending)", pend_dc, pend_byte);
        step();

        check("early_ack", 32'(early_ack_count), 32'd0);
        check("start_overlap", 32'(overlap_count), 32'd0);
        check("data_unstable", 32'(data_change_count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
